// File: rtl/sha256_job_scheduler_if.sv
// Requester and SHA-256 core handshake bundle for the job scheduler.
// master = scheduler side, slave = requesters/core side.
interface sha256_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_msg_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_out_addr;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        err;
    logic                      core_start;
    logic [ADDR_W-1:0]         core_message_addr;
    logic [ADDR_W-1:0]         core_output_addr;
    logic                      core_done;
    logic                      core_rst_n;

    modport master (
        input  req, req_msg_addr, req_out_addr, core_done,
        output ack, err, core_start, core_message_addr, core_output_addr, core_rst_n
    );

    modport slave (
        output req, req_msg_addr, req_out_addr, core_done,
        input  ack, err, core_start, core_message_addr, core_output_addr, core_rst_n
    );
endinterface

// File: rtl/sha256_job_scheduler.sv
// Round-robin sharing of one SHA-256 core among NUM_REQ requesters,
// with a WAIT watchdog that pulses the core reset on a hung job.
module sha256_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned JOB_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sha256_job_scheduler_if.master bus,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [JOB_CNT_W-1:0]   jobs_done
);
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_REC1, S_REC2
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_ack;
    logic [NUM_REQ-1:0]     r_err;
    logic                   r_core_start;
    logic [ADDR_W-1:0]      r_msg_addr;
    logic [ADDR_W-1:0]      r_out_addr;
    logic                   r_core_rst_n;
    logic                   r_busy;
    logic [2:0]             r_grant_id;
    logic [JOB_CNT_W-1:0]   r_jobs_done;
    logic [TMR_W-1:0]       r_timer;

    logic [7:0]             w_req8;
    logic [2:0]             w_idx;
    logic [2:0]             w_winner;
    logic                   w_found;
    logic [ADDR_W-1:0]      w_msg;
    logic [ADDR_W-1:0]      w_out;
    logic [NUM_REQ-1:0]     w_gnt_oh;

    // Widened to 8 bits so a 3-bit index always selects in range.
    assign w_req8 = 8'(bus.req);

    // Search upward from the last grant so the last winner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant_id;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = 3'((32'(r_grant_id) + k) % NUM_REQ);
            if (!w_found && w_req8[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_msg    = '0;
        w_out    = '0;
        w_gnt_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_msg = bus.req_msg_addr[i*ADDR_W +: ADDR_W];
                w_out = bus.req_out_addr[i*ADDR_W +: ADDR_W];
            end
            w_gnt_oh[i] = (r_grant_id == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ack        <= '0;
            r_err        <= '0;
            r_core_start <= 1'b0;
            r_msg_addr   <= '0;
            r_out_addr   <= '0;
            r_core_rst_n <= 1'b1;
            r_busy       <= 1'b0;
            r_grant_id   <= 3'(NUM_REQ - 1);
            r_jobs_done  <= '0;
            r_timer      <= '0;
        end else begin
            r_ack        <= '0;
            r_err        <= '0;
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_state      <= S_ISSUE;
                        r_core_start <= 1'b1;
                        r_grant_id   <= w_winner;
                        r_msg_addr   <= w_msg;
                        r_out_addr   <= w_out;
                        r_busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.core_done) begin
                        r_state     <= S_DONE;
                        r_ack       <= w_gnt_oh;
                        r_jobs_done <= r_jobs_done + 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && r_timer == TMO_LAST) begin
                        r_state      <= S_REC1;
                        r_core_rst_n <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                // Core reset held low across both recovery cycles; ack+err land in the second.
                S_REC1: begin
                    r_state <= S_REC2;
                    r_ack   <= w_gnt_oh;
                    r_err   <= w_gnt_oh;
                end
                S_REC2: begin
                    r_state      <= S_IDLE;
                    r_core_rst_n <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_core_rst_n <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack               = r_ack;
    assign bus.err               = r_err;
    assign bus.core_start        = r_core_start;
    assign bus.core_message_addr = r_msg_addr;
    assign bus.core_output_addr  = r_out_addr;
    assign bus.core_rst_n        = r_core_rst_n;
    assign busy                  = r_busy;
    assign grant_id              = r_grant_id;
    assign jobs_done             = r_jobs_done;
endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler: three instances with watchdog
// limits 4096 (default), 16 and 8.
module tb_sha256_job_scheduler;
    logic clk;
    logic reset_n;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned exp_order [6] = '{0, 1, 3, 0, 1, 3};

    sha256_job_scheduler_if #(.NUM_REQ(4), .ADDR_W(16)) ifa ();
    sha256_job_scheduler_if #(.NUM_REQ(4), .ADDR_W(16)) ifb ();
    sha256_job_scheduler_if #(.NUM_REQ(4), .ADDR_W(16)) ifc ();

    logic        busy_a, busy_b, busy_c;
    logic [2:0]  gid_a, gid_b, gid_c;
    logic [15:0] jobs_a, jobs_b, jobs_c;

    sha256_job_scheduler #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT_CYCLES(4096), .JOB_CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa), .busy(busy_a), .grant_id(gid_a), .jobs_done(jobs_a));
    sha256_job_scheduler #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT_CYCLES(16), .JOB_CNT_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb), .busy(busy_b), .grant_id(gid_b), .jobs_done(jobs_b));
    sha256_job_scheduler #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT_CYCLES(8), .JOB_CNT_W(16)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc), .busy(busy_c), .grant_id(gid_c), .jobs_done(jobs_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    task automatic test_reset();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy_a); end
        n_checks++; if (gid_a !== 3'd3) begin n_fail++; $display("FAIL rst_grant: got %0d expected 3", gid_a); end
        n_checks++; if (jobs_a !== 16'd0) begin n_fail++; $display("FAIL rst_jobs: got %0d expected 0", jobs_a); end
        n_checks++; if (ifa.core_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_core_rst_n: got %0b expected 1", ifa.core_rst_n); end
        n_checks++; if (ifa.core_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %0b expected 0", ifa.core_start); end
        n_checks++; if (ifa.ack !== 4'b0 || ifa.err !== 4'b0) begin n_fail++; $display("FAIL rst_ack_err: got ack=%b err=%b expected 0000", ifa.ack, ifa.err); end
        n_checks++; if (ifa.core_message_addr !== 16'h0 || ifa.core_output_addr !== 16'h0) begin
            n_fail++; $display("FAIL rst_addr: got %h/%h expected 0000/0000", ifa.core_message_addr, ifa.core_output_addr); end
    endtask

    task automatic test_single();
        logic stray;
        ifa.req = 4'b0001;
        @(negedge clk);
        n_checks++; if (ifa.core_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %0b expected 1", ifa.core_start); end
        n_checks++; if (ifa.core_message_addr !== 16'h0000) begin n_fail++; $display("FAIL single_msg: got %h expected 0000", ifa.core_message_addr); end
        n_checks++; if (ifa.core_output_addr !== 16'h0100) begin n_fail++; $display("FAIL single_out: got %h expected 0100", ifa.core_output_addr); end
        n_checks++; if (gid_a !== 3'd0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL single_grant: got gid=%0d busy=%0b expected 0/1", gid_a, busy_a); end
        ifa.req = 4'b0000;
        @(negedge clk);
        n_checks++; if (ifa.core_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %0b expected 0", ifa.core_start); end
        stray = 1'b0;
        for (int k = 2; k <= 150; k++) begin
            @(negedge clk);
            if (ifa.ack !== 4'b0 || ifa.core_rst_n !== 1'b1) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL single_wait_quiet: got %0b expected 0", stray); end
        ifa.core_done = 1'b1;
        @(negedge clk);
        ifa.core_done = 1'b0;
        n_checks++; if (ifa.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ifa.ack); end
        n_checks++; if (ifa.err !== 4'b0000) begin n_fail++; $display("FAIL single_err: got %b expected 0000", ifa.err); end
        n_checks++; if (jobs_a !== 16'd1) begin n_fail++; $display("FAIL single_jobs: got %0d expected 1", jobs_a); end
        @(negedge clk);
        n_checks++; if (ifa.ack !== 4'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL single_after: got ack=%b busy=%0b expected 0000/0", ifa.ack, busy_a); end
        n_checks++; if (ifa.core_message_addr !== 16'h0000 || ifa.core_output_addr !== 16'h0100) begin
            n_fail++; $display("FAIL single_addr_hold: got %h/%h expected 0000/0100", ifa.core_message_addr, ifa.core_output_addr); end
    endtask

    task automatic test_fairness();
        int unsigned cyc;
        logic [3:0] exp_oh;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ifa.req = 4'b1011;
        for (int j = 0; j < 6; j++) begin
            cyc = 0;
            while (ifa.core_start !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
            n_checks++; if (cyc !== ((j == 0) ? 1 : 2)) begin n_fail++; $display("FAIL fair_latency[%0d]: got %0d expected %0d", j, cyc, (j == 0) ? 1 : 2); end
            n_checks++; if (32'(gid_a) !== exp_order[j]) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", j, gid_a, exp_order[j]); end
            repeat (10) @(negedge clk);
            ifa.core_done = 1'b1;
            @(negedge clk);
            ifa.core_done = 1'b0;
            exp_oh = 4'b0001 << exp_order[j];
            n_checks++; if (ifa.ack !== exp_oh || ifa.err !== 4'b0) begin
                n_fail++; $display("FAIL fair_ack[%0d]: got ack=%b err=%b expected %b/0000", j, ifa.ack, ifa.err, exp_oh); end
        end
        ifa.req = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++; if (busy_a !== 1'b0 || jobs_a !== 16'd6) begin n_fail++; $display("FAIL fair_end: got busy=%0b jobs=%0d expected 0/6", busy_a, jobs_a); end
    endtask

    task automatic test_spurious();
        ifa.core_done = 1'b1;
        @(negedge clk);
        ifa.core_done = 1'b0;
        n_checks++; if (ifa.ack !== 4'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL spur_ack: got ack=%b busy=%0b expected 0000/0", ifa.ack, busy_a); end
        @(negedge clk);
        n_checks++; if (ifa.ack !== 4'b0 || jobs_a !== 16'd6 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL spur_after: got ack=%b jobs=%0d busy=%0b expected 0000/6/0", ifa.ack, jobs_a, busy_a); end
        n_checks++; if (gid_a !== 3'd3) begin n_fail++; $display("FAIL spur_grant: got %0d expected 3", gid_a); end
    endtask

    task automatic test_reset_mid_job();
        int unsigned cyc;
        logic stray;
        ifa.req = 4'b0100;
        cyc = 0;
        while (ifa.core_start !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
        n_checks++; if (gid_a !== 3'd2) begin n_fail++; $display("FAIL rmid_grant: got %0d expected 2", gid_a); end
        ifa.req = 4'b0000;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b0 || gid_a !== 3'd3 || jobs_a !== 16'd0) begin
            n_fail++; $display("FAIL rmid_state: got busy=%0b gid=%0d jobs=%0d expected 0/3/0", busy_a, gid_a, jobs_a); end
        n_checks++; if (ifa.core_message_addr !== 16'h0 || ifa.core_output_addr !== 16'h0 || ifa.core_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL rmid_core: got %h/%h rst_n=%0b expected 0000/0000/1", ifa.core_message_addr, ifa.core_output_addr, ifa.core_rst_n); end
        @(negedge clk);
        reset_n = 1'b1;
        stray = 1'b0;
        repeat (3) begin @(negedge clk); if (ifa.ack !== 4'b0 || busy_a !== 1'b0) stray = 1'b1; end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rmid_no_ack: got %0b expected 0", stray); end
        ifa.req = 4'b0100;
        @(negedge clk);
        ifa.req = 4'b0000;
        n_checks++; if (ifa.core_start !== 1'b1 || gid_a !== 3'd2) begin
            n_fail++; $display("FAIL rmid_regrant: got start=%0b gid=%0d expected 1/2", ifa.core_start, gid_a); end
        n_checks++; if (ifa.core_message_addr !== 16'h2222 || ifa.core_output_addr !== 16'h0300) begin
            n_fail++; $display("FAIL rmid_addr: got %h/%h expected 2222/0300", ifa.core_message_addr, ifa.core_output_addr); end
        repeat (3) @(negedge clk);
        ifa.core_done = 1'b1;
        @(negedge clk);
        ifa.core_done = 1'b0;
        n_checks++; if (ifa.ack !== 4'b0100 || jobs_a !== 16'd1) begin
            n_fail++; $display("FAIL rmid_ack: got ack=%b jobs=%0d expected 0100/1", ifa.ack, jobs_a); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int unsigned cyc;
        logic exp_rst;
        logic [3:0] exp_ae;
        ifb.req = 4'b0100;
        cyc = 0;
        while (ifb.core_start !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
        n_checks++; if (ifb.core_start !== 1'b1 || gid_b !== 3'd2) begin
            n_fail++; $display("FAIL tmo_start: got start=%0b gid=%0d expected 1/2", ifb.core_start, gid_b); end
        ifb.req = 4'b0000;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            exp_rst = (k == 17 || k == 18) ? 1'b0 : 1'b1;
            exp_ae  = (k == 18) ? 4'b0100 : 4'b0000;
            n_checks++; if (ifb.core_rst_n !== exp_rst) begin n_fail++; $display("FAIL tmo_rst_n[%0d]: got %0b expected %0b", k, ifb.core_rst_n, exp_rst); end
            n_checks++; if (ifb.ack !== exp_ae || ifb.err !== exp_ae) begin
                n_fail++; $display("FAIL tmo_ack_err[%0d]: got ack=%b err=%b expected %b", k, ifb.ack, ifb.err, exp_ae); end
        end
        n_checks++; if (jobs_b !== 16'd0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL tmo_end: got jobs=%0d busy=%0b expected 0/0", jobs_b, busy_b); end
    endtask

    task automatic test_coincide();
        int unsigned cyc;
        logic stray;
        ifc.req = 4'b0001;
        cyc = 0;
        while (ifc.core_start !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
        n_checks++; if (ifc.core_start !== 1'b1) begin n_fail++; $display("FAIL coin_start: got %0b expected 1", ifc.core_start); end
        ifc.req = 4'b0000;
        stray = 1'b0;
        repeat (8) begin @(negedge clk); if (ifc.core_rst_n !== 1'b1) stray = 1'b1; end
        ifc.core_done = 1'b1;
        @(negedge clk);
        ifc.core_done = 1'b0;
        n_checks++; if (ifc.ack !== 4'b0001 || ifc.err !== 4'b0000) begin
            n_fail++; $display("FAIL coin_ack: got ack=%b err=%b expected 0001/0000", ifc.ack, ifc.err); end
        n_checks++; if (ifc.core_rst_n !== 1'b1 || stray !== 1'b0) begin
            n_fail++; $display("FAIL coin_rst_n: got %0b (stray %0b) expected 1 (0)", ifc.core_rst_n, stray); end
        n_checks++; if (jobs_c !== 16'd1) begin n_fail++; $display("FAIL coin_jobs: got %0d expected 1", jobs_c); end
        @(negedge clk);
        n_checks++; if (ifc.core_rst_n !== 1'b1 || ifc.ack !== 4'b0 || busy_c !== 1'b0 || jobs_c !== 16'd1) begin
            n_fail++; $display("FAIL coin_after: got rst_n=%0b ack=%b busy=%0b jobs=%0d expected 1/0000/0/1", ifc.core_rst_n, ifc.ack, busy_c, jobs_c); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        ifa.req = '0; ifb.req = '0; ifc.req = '0;
        ifa.core_done = 1'b0; ifb.core_done = 1'b0; ifc.core_done = 1'b0;
        ifa.req_msg_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        ifa.req_out_addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        ifb.req_msg_addr = ifa.req_msg_addr; ifb.req_out_addr = ifa.req_out_addr;
        ifc.req_msg_addr = ifa.req_msg_addr; ifc.req_out_addr = ifa.req_out_addr;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_spurious();
        test_reset_mid_job();
        test_timeout();
        test_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
